// File: rtl/sprite_layer_compositor.sv
// Multi-layer sprite compositor: NUM_LAYERS scrolled sprite windows, each with its own
// 16-entry palette, merged by fixed priority (layer 0 highest) with index 0 transparent.
// Two registered stages: window test per layer, then priority select and palette lookup.
// Optional debug outline: define SPRITE_BORDER_EN to paint the edge pixels of the
// highest-priority in-window layer 12'hF00.
module sprite_layer_compositor #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned COLOR_W    = 12,
    parameter int unsigned SCREEN_W   = 320,
    parameter int unsigned SCREEN_H   = 240,
    localparam int unsigned LAYER_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CNT_W-1:0]            h_cnt,
    input  logic [CNT_W-1:0]            v_cnt,
    input  logic                        frame_start,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [NUM_LAYERS*CNT_W-1:0] pos_h,
    input  logic [NUM_LAYERS*CNT_W-1:0] pos_v,
    input  logic [NUM_LAYERS*CNT_W-1:0] size_h,
    input  logic [NUM_LAYERS*CNT_W-1:0] size_v,
    input  logic [NUM_LAYERS*IDX_W-1:0] pix_idx,
    input  logic                        pal_we,
    input  logic [LAYER_W-1:0]          pal_layer,
    input  logic [IDX_W-1:0]            pal_addr,
    input  logic [COLOR_W-1:0]          pal_data,
    output logic [COLOR_W-1:0]          now_pixel,
    output logic                        pixel_hit,
    output logic [LAYER_W-1:0]          hit_layer
);

    localparam int unsigned    PAL_N = 1 << IDX_W;
    localparam logic [CNT_W:0] SCR_W = (CNT_W+1)'(SCREEN_W);
    localparam logic [CNT_W:0] SCR_H = (CNT_W+1)'(SCREEN_H);

    // Shadow position/size, only updated on frame_start so a frame never tears
    logic [CNT_W-1:0] spos_h_q  [NUM_LAYERS];
    logic [CNT_W-1:0] spos_v_q  [NUM_LAYERS];
    logic [CNT_W-1:0] ssize_h_q [NUM_LAYERS];
    logic [CNT_W-1:0] ssize_v_q [NUM_LAYERS];

    logic [COLOR_W-1:0] pal_q [NUM_LAYERS][PAL_N];

    // Stage 1 signals
    logic [CNT_W:0]              x_sum [NUM_LAYERS];
    logic [CNT_W:0]              y_sum [NUM_LAYERS];
    logic [CNT_W:0]              x_d   [NUM_LAYERS];
    logic [CNT_W:0]              y_d   [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]       in_d, in_q;
    logic [NUM_LAYERS*IDX_W-1:0] idx_q;

    // Stage 2 signals
    logic [COLOR_W-1:0] px_d;
    logic               hit_d;
    logic [LAYER_W-1:0] layer_d;
    logic               found;

`ifdef SPRITE_BORDER_EN
    localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);
    logic [NUM_LAYERS-1:0] edge_d, edge_q;
    logic                  top_found;
`endif

    // Latch shadow position/size on frame_start; out-of-range offsets collapse to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                spos_h_q[k]  <= '0;
                spos_v_q[k]  <= '0;
                ssize_h_q[k] <= '0;
                ssize_v_q[k] <= '0;
            end
        end else if (frame_start) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                spos_h_q[k]  <= ({1'b0, pos_h[k*CNT_W +: CNT_W]} >= SCR_W) ?
                                '0 : pos_h[k*CNT_W +: CNT_W];
                spos_v_q[k]  <= ({1'b0, pos_v[k*CNT_W +: CNT_W]} >= SCR_H) ?
                                '0 : pos_v[k*CNT_W +: CNT_W];
                ssize_h_q[k] <= size_h[k*CNT_W +: CNT_W];
                ssize_v_q[k] <= size_v[k*CNT_W +: CNT_W];
            end
        end
    end

    // Palette write port; a layer select with no matching layer writes nothing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                for (int e = 0; e < PAL_N; e++) begin
                    pal_q[k][e] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                if (pal_we && (pal_layer == LAYER_W'(k))) begin
                    pal_q[k][pal_addr] <= pal_data;
                end
            end
        end
    end

    // Stage 1 combinational: wrapped sprite-local coordinates and window test
    always_comb begin
        in_d = '0;
`ifdef SPRITE_BORDER_EN
        edge_d = '0;
`endif
        for (int k = 0; k < NUM_LAYERS; k++) begin
            x_sum[k] = {1'b0, h_cnt} + {1'b0, spos_h_q[k]};
            y_sum[k] = {1'b0, v_cnt} + {1'b0, spos_v_q[k]};
            x_d[k]   = (x_sum[k] >= SCR_W) ? (x_sum[k] - SCR_W) : x_sum[k];
            y_d[k]   = (y_sum[k] >= SCR_H) ? (y_sum[k] - SCR_H) : y_sum[k];
            in_d[k]  = layer_en[k] && (x_d[k] < {1'b0, ssize_h_q[k]}) &&
                       (y_d[k] < {1'b0, ssize_v_q[k]});
`ifdef SPRITE_BORDER_EN
            edge_d[k] = (x_d[k] == '0) || (x_d[k] == ({1'b0, ssize_h_q[k]} - ONE)) ||
                        (y_d[k] == '0) || (y_d[k] == ({1'b0, ssize_v_q[k]} - ONE));
`endif
        end
    end

    // Stage 1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q  <= '0;
            idx_q <= '0;
`ifdef SPRITE_BORDER_EN
            edge_q <= '0;
`endif
        end else begin
            in_q  <= in_d;
            idx_q <= pix_idx;
`ifdef SPRITE_BORDER_EN
            edge_q <= edge_d;
`endif
        end
    end

    // Stage 2 combinational: lowest-numbered opaque layer wins
    always_comb begin
        px_d    = '0;
        hit_d   = 1'b0;
        layer_d = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (!found && in_q[k] && (idx_q[k*IDX_W +: IDX_W] != '0)) begin
                found   = 1'b1;
                px_d    = pal_q[k][idx_q[k*IDX_W +: IDX_W]];
                hit_d   = 1'b1;
                layer_d = LAYER_W'(k);
            end
        end
`ifdef SPRITE_BORDER_EN
        // Outline follows the top in-window layer even where it is transparent
        top_found = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (!top_found && in_q[k]) begin
                top_found = 1'b1;
                if (edge_q[k]) begin
                    px_d    = COLOR_W'(12'hF00);
                    hit_d   = 1'b1;
                    layer_d = LAYER_W'(k);
                end
            end
        end
`endif
    end

    // Stage 2 register driving the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_pixel <= '0;
            pixel_hit <= 1'b0;
            hit_layer <= '0;
        end else begin
            now_pixel <= px_d;
            pixel_hit <= hit_d;
            hit_layer <= layer_d;
        end
    end

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Bench for sprite_layer_compositor: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a frame-level model of the compositor.
module tb_sprite_layer_compositor;

    localparam int NL  = 4;
    localparam int CW  = 10;
    localparam int IW  = 4;
    localparam int COL = 12;
    localparam int SW  = 320;
    localparam int SH  = 240;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [CW-1:0]      h_cnt = '0;
    logic [CW-1:0]      v_cnt = '0;
    logic               frame_start = 1'b0;
    logic [NL-1:0]      layer_en = '0;
    logic [NL*CW-1:0]   pos_h = '0;
    logic [NL*CW-1:0]   pos_v = '0;
    logic [NL*CW-1:0]   size_h = '0;
    logic [NL*CW-1:0]   size_v = '0;
    logic [NL*IW-1:0]   pix_idx = '0;
    logic               pal_we = 1'b0;
    logic [1:0]         pal_layer = '0;
    logic [IW-1:0]      pal_addr = '0;
    logic [COL-1:0]     pal_data = '0;
    logic [COL-1:0]     now_pixel;
    logic               pixel_hit;
    logic [1:0]         hit_layer;

    int checks = 0;
    int errors = 0;
    bit run_chk = 1'b0;

    sprite_layer_compositor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .frame_start(frame_start),
        .layer_en   (layer_en),
        .pos_h      (pos_h),
        .pos_v      (pos_v),
        .size_h     (size_h),
        .size_v     (size_v),
        .pix_idx    (pix_idx),
        .pal_we     (pal_we),
        .pal_layer  (pal_layer),
        .pal_addr   (pal_addr),
        .pal_data   (pal_data),
        .now_pixel  (now_pixel),
        .pixel_hit  (pixel_hit),
        .hit_layer  (hit_layer)
    );

    always #5 clk = ~clk;

    // Reference model state
    int             sph [NL];
    int             spv [NL];
    int             ssh [NL];
    int             ssv [NL];
    logic [COL-1:0] mpal [NL][16];
    bit             pin [NL];
    int             pidx [NL];
    bit             pedge [NL];
    logic [COL-1:0] e_px = '0;
    bit             e_hit = 1'b0;
    int             e_layer = 0;
    int             win, bwin, mx, my, p;

    task automatic model_clear();
        for (int k = 0; k < NL; k++) begin
            sph[k] = 0; spv[k] = 0; ssh[k] = 0; ssv[k] = 0;
            pin[k] = 1'b0; pidx[k] = 0; pedge[k] = 1'b0;
            for (int e = 0; e < 16; e++) mpal[k][e] = '0;
        end
        e_px = '0; e_hit = 1'b0; e_layer = 0;
    endtask

    initial model_clear();

    // Model: pixel seen at edge N is resolved at edge N+1 with the palette as it was then
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            win = -1;
            for (int k = NL - 1; k >= 0; k--) if (pin[k] && pidx[k] != 0) win = k;
            e_px = '0; e_hit = 1'b0; e_layer = 0;
            if (win >= 0) begin
                e_px = mpal[win][pidx[win]]; e_hit = 1'b1; e_layer = win;
            end
`ifdef SPRITE_BORDER_EN
            bwin = -1;
            for (int k = NL - 1; k >= 0; k--) if (pin[k]) bwin = k;
            if (bwin >= 0 && pedge[bwin]) begin
                e_px = 12'hF00; e_hit = 1'b1; e_layer = bwin;
            end
`endif
            for (int k = 0; k < NL; k++) begin
                mx = (int'(h_cnt) + sph[k]) % SW;
                my = (int'(v_cnt) + spv[k]) % SH;
                pin[k]   = layer_en[k] && mx < ssh[k] && my < ssv[k];
                pidx[k]  = int'(pix_idx[k*IW +: IW]);
                pedge[k] = (mx == 0) || (mx == ssh[k] - 1) || (my == 0) || (my == ssv[k] - 1);
            end
            if (pal_we) mpal[pal_layer][pal_addr] = pal_data;
            if (frame_start) begin
                for (int k = 0; k < NL; k++) begin
                    p = int'(pos_h[k*CW +: CW]);  sph[k] = (p >= SW) ? 0 : p;
                    p = int'(pos_v[k*CW +: CW]);  spv[k] = (p >= SH) ? 0 : p;
                    ssh[k] = int'(size_h[k*CW +: CW]);
                    ssv[k] = int'(size_v[k*CW +: CW]);
                end
            end
        end
    end

    // Per-cycle compare of DUT against model, away from the active edge
    always @(negedge clk) begin
        if (run_chk) begin
            checks++;
            if (now_pixel !== e_px || pixel_hit !== e_hit || hit_layer !== 2'(e_layer)) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got px=%h hit=%0b layer=%0d want px=%h hit=%0b layer=%0d",
                         $time, now_pixel, pixel_hit, hit_layer, e_px, e_hit, e_layer);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Literal expectation pins both the DUT and the model
    task automatic check_lit(input string name, input logic [COL-1:0] px, input bit hit,
                             input int layer);
        checks++;
        if (now_pixel !== px || pixel_hit !== hit || hit_layer !== 2'(layer) ||
            e_px !== px || e_hit != hit || e_layer != layer) begin
            errors++;
            $display("FAIL %s: dut px=%h hit=%0b layer=%0d model px=%h hit=%0b layer=%0d want px=%h hit=%0b layer=%0d",
                     name, now_pixel, pixel_hit, hit_layer, e_px, e_hit, e_layer, px, hit, layer);
        end
    endtask

    task automatic pal_write(input int l, input int a, input logic [COL-1:0] d);
        pal_we = 1'b1; pal_layer = 2'(l); pal_addr = IW'(a); pal_data = d;
        tick();
        pal_we = 1'b0;
    endtask

    task automatic latch();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic randomize_inputs();
        h_cnt = CW'($urandom_range(0, SW - 1));
        v_cnt = CW'($urandom_range(0, SH - 1));
        layer_en = NL'($urandom);
        frame_start = ($urandom_range(0, 15) == 0);
        for (int k = 0; k < NL; k++) begin
            pos_h[k*CW +: CW]  = CW'($urandom_range(0, 350));
            pos_v[k*CW +: CW]  = CW'($urandom_range(0, 270));
            size_h[k*CW +: CW] = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 400))
                                                             : CW'($urandom_range(0, 64));
            size_v[k*CW +: CW] = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 400))
                                                             : CW'($urandom_range(0, 64));
        end
        pix_idx   = (NL*IW)'($urandom);
        pal_we    = ($urandom_range(0, 2) == 0);
        pal_layer = 2'($urandom);
        pal_addr  = IW'($urandom);
        pal_data  = COL'($urandom);
    endtask

    initial begin
        #3 rst_n = 1'b0;
        run_chk = 1'b1;

        // Reset held with random inputs
        for (int i = 0; i < 8; i++) begin
            randomize_inputs();
            tick();
            check_lit("reset", 12'h000, 1'b0, 0);
        end
        frame_start = 1'b0; pal_we = 1'b0; layer_en = '0; pix_idx = '0;
        h_cnt = '0; v_cnt = '0; pos_h = '0; pos_v = '0;
        rst_n = 1'b1;
        tick();

        // Basic hit and miss
        pal_write(0, 3, 12'hABC);
        for (int k = 0; k < NL; k++) begin
            size_h[k*CW +: CW] = CW'(16);
            size_v[k*CW +: CW] = CW'(16);
        end
        layer_en = 4'b0001;
        latch();
        h_cnt = CW'(5); v_cnt = CW'(5); pix_idx = 16'h0003;
        tick(); tick();
        check_lit("basic_hit", 12'hABC, 1'b1, 0);
        h_cnt = CW'(16);
        tick(); tick();
        check_lit("basic_miss", 12'h000, 1'b0, 0);

        // Horizontal wrap
        pos_h[0 +: CW] = CW'(310);
        latch();
        h_cnt = CW'(5);
        tick(); tick();
        check_lit("wrap_out", 12'h000, 1'b0, 0);
        h_cnt = CW'(12);
        tick(); tick();
        check_lit("wrap_in", 12'hABC, 1'b1, 0);

        // Priority and transparency
        pos_h[0 +: CW] = '0;
        latch();
        layer_en = 4'b0011;
        pal_write(1, 2, 12'h0F0);
        h_cnt = CW'(5); v_cnt = CW'(5); pix_idx = 16'h0020;
        tick(); tick();
        check_lit("transparent_l0", 12'h0F0, 1'b1, 1);
        pix_idx = 16'h0021;
        tick(); tick();
        check_lit("priority_l0", 12'h000, 1'b1, 0);

        // Shadow registers ignore pos changes until frame_start
        pix_idx = 16'h0023;
        pos_h[0 +: CW] = CW'(310);
        tick(); tick();
        check_lit("shadow_hold", 12'hABC, 1'b1, 0);
        latch();
        tick();
        check_lit("shadow_old_cycle", 12'hABC, 1'b1, 0);
        tick();
        check_lit("shadow_new", 12'h0F0, 1'b1, 1);

        // Palette write/read collision
        pos_h[0 +: CW] = '0;
        latch();
        layer_en = 4'b0001;
        tick(); tick();
        check_lit("pre_collide", 12'hABC, 1'b1, 0);
        pal_we = 1'b1; pal_layer = 2'd0; pal_addr = IW'(3); pal_data = 12'h123;
        tick();
        pal_we = 1'b0;
        check_lit("collide_old", 12'hABC, 1'b1, 0);
        tick();
        check_lit("collide_new", 12'h123, 1'b1, 0);

        // Left edge of the window
        h_cnt = '0;
        tick(); tick();
`ifdef SPRITE_BORDER_EN
        check_lit("border_edge", 12'hF00, 1'b1, 0);
`else
        check_lit("left_edge", 12'h123, 1'b1, 0);
`endif

        // Randomized traffic with occasional mid-stream resets
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            randomize_inputs();
            tick();
        end
        rst_n = 1'b1;
        tick(); tick(); tick();
        run_chk = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
